// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular fetch queue of {PC, instr} pairs between F and D stages,
//            with single-cycle redirect flush. Optional macro FETCH_ADEL_CHECK_EN
//            tags misaligned / out-of-range PCs as fetch address errors.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_exc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          push, pop;
  logic [31:0]   wr_instr;

  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

`ifdef FETCH_ADEL_CHECK_EN
  logic exc_new;
  logic exc_mem_q [DEPTH];

  // Misaligned or outside the instruction window: store a nop and flag it.
  assign exc_new  = (in_pc[1:0] != 2'b00) || (in_pc < 32'h0000_3000) ||
                    (in_pc > 32'h0000_6FFF);
  assign wr_instr = exc_new ? 32'h0000_0000 : in_instr;
  assign out_exc  = out_valid ? exc_mem_q[rd_ptr_q] : 1'b0;
`else
  assign wr_instr = in_instr;
  assign out_exc  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= wr_instr;
`ifdef FETCH_ADEL_CHECK_EN
      exc_mem_q[wr_ptr_q]   <= exc_new;
`endif
    end
  end

  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Scoreboard bench for fetch_queue (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_exc;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return ~pc ^ 32'h1357_9BDF;
  endfunction

  function automatic logic exc_of(input logic [31:0] pc);
`ifdef FETCH_ADEL_CHECK_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic r, input logic f);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = r;
    flush     = f;
  endtask

  // Advance one edge; the scoreboard follows the queue's intended behaviour.
  task automatic step();
    ent_t e;
    logic acc, deq;
    acc = in_valid && (sb.size() < DEPTH);
    deq = out_ready && (sb.size() > 0);
    if (flush) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (acc) begin
        e.pc    = in_pc;
        e.exc   = exc_of(in_pc);
        e.instr = e.exc ? 32'h0 : in_instr;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    tests++; if (count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (out_exc !== 1'b0) begin fails++; $display("FAIL reset_out_exc got %b exp 0", out_exc); end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step(); step();
    tests++; if (count !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL idle_after_reset count %0d valid %b exp 0 0", count, out_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
      step();
      tests++; if (count !== CW'(i + 1)) begin fails++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    drive(1'b1, 32'h3010, 1'b0, 1'b0);
    step();
    tests++; if (count !== CW'(DEPTH)) begin fails++; $display("FAIL overfill_count got %0d exp %0d", count, DEPTH); end
    tests++; if (out_pc !== 32'h3000) begin fails++; $display("FAIL overfill_head got %h exp 00003000", out_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc = 32'h3010;
    logic [31:0] last_pc = 32'h2FFC;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, next_pc, 1'b1, 1'b0);
      tests++;
      if (sb.size() == 0 || out_valid !== 1'b1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr || out_exc !== sb[0].exc) begin
        fails++; $display("FAIL wrap_head got %b/%h/%h/%b", out_valid, out_pc, out_instr, out_exc);
      end
      tests++; if (out_pc !== last_pc + 32'd4) begin fails++; $display("FAIL wrap_order got %h exp %h", out_pc, last_pc + 32'd4); end
      last_pc = out_pc;
      if (in_ready) next_pc = next_pc + 32'd4;
      step();
      tests++; if (count !== CW'(sb.size())) begin fails++; $display("FAIL wrap_count got %0d exp %0d", count, sb.size()); end
    end
    for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
        fails++; $display("FAIL drain_head got %h/%h exp %h/%h", out_pc, out_instr, sb[0].pc, sb[0].instr);
      end
      step();
    end
    tests++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin fails++; $display("FAIL empty_outputs got %b/%h/%h exp 0/0/0", out_valid, out_pc, out_instr); end
    step();
    tests++; if (count !== '0) begin fails++; $display("FAIL empty_pop_count got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h3100, 1'b0, 1'b0); step();
    drive(1'b1, 32'h3104, 1'b0, 1'b0); step();
    tests++; if (count !== CW'(2)) begin fails++; $display("FAIL b2b_prefill got %0d exp 2", count); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h3108 + 32'(4 * i), 1'b1, 1'b0);
      tests++;
      if (sb.size() == 0 || out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
        fails++; $display("FAIL b2b_head got %h/%h", out_pc, out_instr);
      end
      step();
      tests++; if (count !== CW'(2)) begin fails++; $display("FAIL b2b_count got %0d exp 2", count); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h3200, 1'b0, 1'b0); step();
    tests++; if (count !== CW'(3)) begin fails++; $display("FAIL flush_pre got %0d exp 3", count); end
    drive(1'b1, 32'h5000, 1'b1, 1'b1); step();
    tests++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_state got cnt %0d valid %b rdy %b exp 0 0 1", count, out_valid, in_ready);
    end
    drive(1'b1, 32'h4000, 1'b0, 1'b0); step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h4000 || count !== CW'(1)) begin
      fails++; $display("FAIL flush_repush got %b/%h/%0d exp 1/00004000/1", out_valid, out_pc, count);
    end
    tests++; if (out_instr !== instr_of(32'h4000)) begin fails++; $display("FAIL flush_repush_instr got %h exp %h", out_instr, instr_of(32'h4000)); end
    drive(1'b0, 32'h0, 1'b0, 1'b1); step();
  endtask

  task automatic test_adel();
    logic [31:0] pcs [3];
    pcs[0] = 32'h3002; pcs[1] = 32'h7000; pcs[2] = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], 1'b0, 1'b0); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (sb.size() == 0 || out_pc !== sb[0].pc || out_instr !== sb[0].instr || out_exc !== sb[0].exc) begin
        fails++; $display("FAIL adel_head got %h/%h/%b", out_pc, out_instr, out_exc);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h3300, 1'b0, 1'b0); step();
    drive(1'b1, 32'h3304, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    sb.delete();
    tests++; if (count !== '0 || out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset got cnt %0d valid %b pc %h rdy %b", count, out_valid, out_pc, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 32'h6000, 1'b0, 1'b0); step();
    tests++; if (out_pc !== 32'h6000 || count !== CW'(1)) begin
      fails++; $display("FAIL post_reset_push got %h/%0d exp 00006000/1", out_pc, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_adel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting directly downstream of the F-stage PC register and instruction memory, and upstream of the D stage. It buffers up to DEPTH fetched {PC, instruction} pairs so that D-stage stalls do not immediately freeze fetch. Its `in_ready` output drives the PC register's write enable, and its head entry feeds the D-stage pipeline register. A branch or jump redirect flushes it in one cycle.

## Interface
- `DEPTH`, 4, number of entries; power of two, minimum 2
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  F stage presents a fetched pair this cycle
- `in_pc`  input  32  PC of the fetched instruction
- `in_instr`  input  32  instruction word read at `in_pc`
- `in_ready`  output  1  queue can accept a push; feeds PC write enable
- `out_valid`  output  1  head entry valid
- `out_pc`  output  32  head entry PC
- `out_instr`  output  32  head entry instruction
- `out_exc`  output  1  head entry carries a fetch address error (see Configuration)
- `out_ready`  input  1  D stage consumes the head this cycle (not stalled)
- `flush`  input  1  redirect; discard all entries
- `count`  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits, wrap from DEPTH-1 to 0; `count` ranges 0..DEPTH.
- Push when `in_valid && in_ready`: write {in_pc, in_instr, exc} at `wr_ptr`, increment `wr_ptr`.
- Pop when `out_valid && out_ready`: increment `rd_ptr`.
- `in_ready = (count != DEPTH)`; registered-state only, no combinational path from `out_ready`.
- `out_valid = (count != 0)`; `out_pc`, `out_instr`, `out_exc` are the head entry when valid, forced to 0 when `out_valid` is 0.
- Push and pop in the same cycle: both take effect; `count` is unchanged.
- Full: `in_ready` = 0 even if a pop occurs that cycle; `in_valid` is ignored, no entry is overwritten.
- Empty: `out_ready` is ignored; `rd_ptr` does not move.
- `flush` has priority over push and pop. Next edge: `count` = 0, `wr_ptr` = `rd_ptr` = 0, and any push or pop in that cycle is discarded.
- Storage array is not reset; only the pointers and `count` are reset.

## Timing
- Reset (`reset` = 0, asynchronous): `count` = 0, pointers = 0. `out_valid` = 0 and `out_pc` = `out_instr` = `out_exc` = 0 immediately. `in_ready` = 1.
- Push-to-output latency: 1 cycle. An entry pushed at edge N is presented at the head after edge N (if the queue was empty).
- Throughput: 1 push and 1 pop per cycle sustained.
- Flush asserted in cycle N: `out_valid` = 0 and `in_ready` = 1 after edge N. A push with the redirected PC is accepted from cycle N+1.
- Reset asserted mid-operation: all entries are lost at once. First push is accepted in the first cycle after deassertion.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - At push, `exc` = 1 if `in_pc[1:0] != 0` or `in_pc` lies outside 0x00003000..0x00006FFF.
  - Such entries store `in_instr` as 0x00000000 (nop).
  - `out_exc` reflects the stored flag.
- Not defined: `exc` is not stored, `out_exc` is tied 0, and `in_instr` is stored unmodified.

## Test plan
- Reset then idle -> `in_ready`=1, `out_valid`=0, `out_pc`=0, `count`=0.
- Push PCs 0x3000, 0x3004, 0x3008, 0x300C with `out_ready`=0 (DEPTH=4) -> `count`=4 and `in_ready`=0. A fifth push of 0x3010 is ignored; head is still 0x3000.
- From full, hold `out_ready`=1 and keep pushing -> pops return 0x3000, 0x3004… in order across the pointer wrap, with no loss or duplication.
- Simultaneous push and pop at `count`=2 -> `count` stays 2; output order is preserved.
- `flush` with `count`=3 and `in_valid`=1 -> next cycle `count`=0, `out_valid`=0. The pushed pair is dropped; a push of 0x4000 the following cycle appears at the head one cycle later.
- With `FETCH_ADEL_CHECK_EN`: push 0x3002 and 0x7000 -> both entries show `out_exc`=1, `out_instr`=0. Push 0x3008 -> `out_exc`=0.
